// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default geometry and header-check helper.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned CNT_W      = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR1   = 3'd1,
        S_DATA   = 3'd2,
        S_COMMIT = 3'd3,
        S_RUN    = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    // A header is unusable when it asks for nothing or for more than fits.
    function automatic logic hdr_bad(input logic [CNT_W-1:0] cnt, input int unsigned depth);
        return (cnt == '0) || (32'(cnt) > depth);
    endfunction

endpackage

// File: rtl/m_imem_loader_byte_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses the cycle
// after the fourth byte, with the finished word on `word`.
module m_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_accept,
    input  logic [7:0]  in_byte,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] shreg_q, shreg_d;
    logic        valid_q, valid_d;

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        if (clear) begin
            idx_d = '0;
        end else if (in_accept) begin
            // Shift in at the top so byte 0 lands in [7:0] after four bytes.
            shreg_d = {in_byte, shreg_q[31:8]};
            idx_d   = idx_q + 2'd1;
            valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

    assign last_byte  = in_accept && !clear && (idx_q == 2'd3);
    assign word_valid = valid_q;
    assign word       = shreg_q;

endmodule

// File: rtl/m_imem_loader.sv
// Byte-stream loader for the core's instruction memory: header, data words,
// commit, then run until the core halts.
module m_imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              w_clock,
    input  logic              w_reset,
    input  logic              w_in_valid,
    input  logic [7:0]        w_in_data,
    output logic              w_in_ready,
    output logic              w_imem_we,
    output logic [ADDR_W-1:0] w_imem_addr,
    output logic [31:0]       w_imem_wd,
    output logic              w_core_run,
    input  logic              w_halt,
    output logic              w_done,
    output logic              w_err,
    output logic [ADDR_W:0]   w_loaded
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              accept;
    logic              hdr_accept;
    logic              data_accept;
    logic              last_byte;
    logic [CNT_W-1:0]  hdr_full;

    assign w_in_ready  = (state_q == S_IDLE) || (state_q == S_HDR1) ||
                         (state_q == S_DATA) || (state_q == S_HALT);
    assign accept      = w_in_valid && w_in_ready;
    assign hdr_accept  = accept && (state_q == S_HDR1);
    assign data_accept = accept && (state_q == S_DATA);
    assign hdr_full    = {w_in_data, count_q[7:0]};

    m_byte_assembler u_asm (
        .clk        (w_clock),
        .rst        (w_reset),
        .clear      (w_reset || hdr_accept),
        .in_accept  (data_accept),
        .in_byte    (w_in_data),
        .last_byte  (last_byte),
        .word_valid (w_imem_we),
        .word       (w_imem_wd)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (accept) begin
                    count_d = {{(CNT_W-8){1'b0}}, w_in_data};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    count_d = hdr_full;
                    if (hdr_bad(hdr_full, DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        widx_d  = '0;
                    end
                end
            end
            S_DATA: begin
                // Address and word count are registered alongside the
                // assembler's word so all three appear in the write cycle.
                if (last_byte) begin
                    addr_d = widx_q[ADDR_W-1:0];
                    widx_d = widx_q + 1'b1;
                    if (CNT_W'(widx_q) + 1'b1 == count_q) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: state_d = S_RUN;
            S_RUN: begin
                if (w_halt) begin
                    state_d = S_HALT;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            widx_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            addr_q  <= addr_d;
        end
    end

    assign w_imem_addr = addr_q;
    assign w_loaded    = widx_q;
    assign w_core_run  = (state_q == S_RUN);
    assign w_done      = (state_q == S_HALT);
    assign w_err       = (state_q == S_ERR);

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed sequence with random payloads; expected imem writes are derived
// from the word lists being streamed.
module tb_m_imem_loader;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          vin;
    logic [7:0]    din;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          run;
    logic          halt;
    logic          done;
    logic          err;
    logic [AW:0]   loaded;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] words_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_wd_q[$];

    m_imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .w_clock     (clk),
        .w_reset     (rst),
        .w_in_valid  (vin),
        .w_in_data   (din),
        .w_in_ready  (rdy),
        .w_imem_we   (we),
        .w_imem_addr (addr),
        .w_imem_wd   (wd),
        .w_core_run  (run),
        .w_halt      (halt),
        .w_done      (done),
        .w_err       (err),
        .w_loaded    (loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_addr_q.push_back(32'(addr));
            obs_wd_q.push_back(wd);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vin  = 1'b0;
        halt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present a byte after `gap` idle cycles and hold it until accepted.
    task automatic send(input logic [7:0] b, input int unsigned gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        vin = 1'b1;
        din = b;
        for (int t = 0; t < 20; t++) begin
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 vin = 1'b0;
        chk("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, obs_addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
            chk({tag, "_addr"}, obs_addr_q[i], exp_addr_q[i]);
            chk({tag, "_wd"}, obs_wd_q[i], exp_wd_q[i]);
        end
        obs_addr_q.delete();
        obs_wd_q.delete();
        exp_addr_q.delete();
        exp_wd_q.delete();
    endtask

    // Stream header + words_q, then check the commit cycle and run entry.
    task automatic load(input string tag, input int unsigned n, input int unsigned gmin,
                        input int unsigned gmax);
        logic [15:0] hdr;
        hdr = 16'(n);
        send(hdr[7:0], $urandom_range(gmax, gmin));
        @(negedge clk);
        chk({tag, "_hdr1_done"}, 32'(done), 32'd0);
        chk({tag, "_hdr1_ready"}, 32'(rdy), 32'd1);
        send(hdr[15:8], $urandom_range(gmax, gmin));
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(32'(i));
            exp_wd_q.push_back(words_q[i]);
            for (int k = 0; k < 4; k++) begin
                send(8'(words_q[i] >> (8 * k)), $urandom_range(gmax, gmin));
            end
        end
        @(negedge clk);
        chk({tag, "_commit_we"}, 32'(we), 32'd1);
        chk({tag, "_commit_run"}, 32'(run), 32'd0);
        @(negedge clk);
        chk({tag, "_run"}, 32'(run), 32'd1);
        chk({tag, "_loaded"}, 32'(loaded), n);
        chk({tag, "_ready_run"}, 32'(rdy), 32'd0);
        repeat (3) @(negedge clk);
        check_writes(tag);
    endtask

    task automatic bad_header(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        send(lo, 0);
        send(hi, 0);
        @(negedge clk);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_ready"}, 32'(rdy), 32'd0);
        chk({tag, "_run"}, 32'(run), 32'd0);
        vin = 1'b1;
        repeat (4) @(negedge clk);
        vin = 1'b0;
        chk({tag, "_err_sticky"}, 32'(err), 32'd1);
        check_writes(tag);
    endtask

    initial begin
        rst  = 1'b1;
        vin  = 1'b0;
        din  = 8'h00;
        halt = 1'b0;
        do_reset();

        // Reset state and halt ignored while idle.
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd1);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
        chk("idle_halt_done", 32'(done), 32'd0);
        chk("idle_halt_ready", 32'(rdy), 32'd1);

        // Two-word program, back-to-back bytes.
        words_q = '{32'h00500093, 32'h00108133};
        load("t1", 2, 0, 0);

        // Halt from RUN, then reload one word.
        @(negedge clk);
        halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        @(negedge clk);
        chk("halt_run", 32'(run), 32'd0);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_ready", 32'(rdy), 32'd1);
        words_q = '{$urandom()};
        load("t4", 1, 0, 2);

        // Same two-word program with 3-cycle gaps.
        do_reset();
        words_q = '{32'h00500093, 32'h00108133};
        load("t2", 2, 3, 3);

        // Bad headers stick in error until reset.
        do_reset();
        bad_header("t3zero", 8'h00, 8'h00);
        do_reset();
        bad_header("t3big", 8'h41, 8'h00);
        do_reset();
        words_q = '{$urandom(), $urandom(), $urandom()};
        load("t3ok", 3, 0, 2);

        // Reset in the middle of a two-word load.
        do_reset();
        words_q = '{$urandom(), $urandom()};
        send(8'h02, 0);
        send(8'h00, 0);
        exp_addr_q.push_back(32'd0);
        exp_wd_q.push_back(words_q[0]);
        for (int k = 0; k < 4; k++) send(8'(words_q[0] >> (8 * k)), 0);
        send(words_q[1][7:0], 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_we", 32'(we), 32'd0);
        chk("mid_addr", 32'(addr), 32'd0);
        chk("mid_wd", wd, 32'd0);
        chk("mid_run", 32'(run), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_loaded", 32'(loaded), 32'd0);
        chk("mid_ready", 32'(rdy), 32'd1);
        check_writes("t5pre");
        words_q = '{32'hDEADBEEF};
        load("t5", 1, 0, 0);

        // Full-depth load.
        do_reset();
        words_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) words_q.push_back($urandom());
        load("t6", DEPTH, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
